matrix_scan_ctrl: RTL and testbench
===================================

Name: matrix_scan_ctrl

Overview:
- Scan sequencer for the 32x16 RGB LED matrix panel. The panel is driven as two half-panels, so each scanned row carries 6 colour bits: top R,G,B and bottom R,G,B.
- The controller reads one row-pair at a time from the synchronous-read frame buffer. It shifts that row out on rgb/outclk, latches it, and drives the row address abc. It then enables output for a fixed dwell before advancing to the next row.
- It sits between the game-state frame buffer and the panel pins, and replaces free-running display logic with an explicitly sequenced FSM.

Parameters:
- COLS, 32, columns per row (outclk rising edges per row).
- ROW_PAIRS, 8, scanned row pairs; abc width is clog2(ROW_PAIRS) = 3.
- DWELL, 64, cycles oe is held low (display on) per row; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; sampled only at row boundaries.
- pix_in  input  6  frame-buffer read data {r1,g1,b1,r2,g2,b2}; valid the cycle after rd_row/rd_col are presented.
- rd_row  output  3  frame-buffer read row-pair address.
- rd_col  output  5  frame-buffer read column address.
- rgb  output  6  panel colour data.
- outclk  output  1  panel shift clock.
- lat  output  1  panel latch strobe, active high.
- oe  output  1  panel output enable, active low (1 = blanked).
- abc  output  3  panel row-pair select.
- frame_done  output  1  one-cycle pulse at the end of the last row's DISPLAY.

Behaviour:
- All outputs are registered.
- Reset (async, immediate, including mid-row):
  - state = IDLE, row = 0.
  - rgb = 0, outclk = 0, lat = 0, oe = 1, abc = 0, rd_row = 0, rd_col = 0, frame_done = 0.
  - Reset aborts any partial shift. No latch is issued for that row.
- States: IDLE, FETCH, SHIFT, LATCH, DISPLAY.
- IDLE:
  - oe = 1, outclk = 0, lat = 0.
  - If en = 1, go to FETCH next cycle with row unchanged.
- FETCH (1 cycle):
  - rd_row = row, rd_col = 0.
  - At exit, rgb <= pix_in is not yet valid. The column-0 capture happens at the end of the first SHIFT cycle (see below).
- SHIFT (2*COLS + 1 cycles, k = 0..2*COLS):
  - k = 0: rd_col = 1. At the end of the cycle, rgb <= pix_in (column 0) and outclk stays 0.
  - Odd k: at the end of the cycle, outclk <= 1.
  - Even k >= 2: at the end of the cycle, outclk <= 0. In the same cycle, rd_col = min(k/2 + 1, COLS - 1), and at its end rgb <= pix_in (column k/2). At k = 2*COLS, rgb <= 0 instead.
  - Net result: rgb changes only together with an outclk fall. rgb is stable for at least 1 cycle before and after each outclk rise.
  - Exactly COLS rising edges per row; column c is presented on rise c+1.
  - rd_row is held at row throughout.
- LATCH (1 cycle):
  - lat = 1, oe = 1, abc <= row (abc changes on LATCH entry).
  - outclk = 0, rgb = 0.
- DISPLAY (DWELL cycles):
  - oe = 0, lat = 0, abc = row.
  - On the last cycle, oe returns to 1 at the exit edge.
  - Row advance: row <= (row + 1) mod ROW_PAIRS; wrap from ROW_PAIRS-1 to 0.
  - frame_done = 1 for exactly the cycle following the DISPLAY of row ROW_PAIRS-1.
  - If en = 1, go to FETCH; otherwise go to IDLE.
- en:
  - Deasserting en mid-row has no effect until DISPLAY ends. The current row always completes.
  - Reasserting en in IDLE resumes at the stored row; there is no restart at 0.
- Row period = 1 + (2*COLS + 1) + 1 + DWELL. Defaults: 1 + 65 + 1 + 64 = 131 cycles; frame = 1048 cycles.
- oe and lat are never 0 and 1 respectively in the same cycle. oe = 0 never overlaps outclk activity.

Test Plan:
- Reset then en = 1, frame buffer returns pix_in = {3'b0, rd_col[2:0]} -> FETCH begins 1 cycle after reset release. Required response:
  - 32 outclk rises.
  - On rise c, rgb == c mod 8.
  - lat pulses 1 cycle with abc = 0.
  - oe low for exactly 64 cycles.
  - Next FETCH starts at cycle 131.
- Run a full frame with en = 1 -> abc sequence 0,1,...,7,0. frame_done pulses once at cycle 1048 relative to the first FETCH, then again every 1048 cycles.
- Deassert en during SHIFT of row 3 -> row 3 completes its latch and full dwell, then IDLE with oe = 1. Reassert en 20 cycles later -> FETCH of row 4.
- Assert reset in the middle of DISPLAY of row 5 -> same cycle (async): oe = 1, abc = 0, lat = 0, rgb = 0. After release, scanning restarts at row 0.
- Protocol checker over 3 frames -> all of the following hold:
  - rgb never changes on the same edge as an outclk rise.
  - lat is never high while oe = 0.
  - rd_col never exceeds 31.
- Parameter override COLS = 4, ROW_PAIRS = 2, DWELL = 1 -> row period 12 cycles, 4 outclk rises per row, abc alternates 0,1.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// Row-pair scan sequencer for the 32x16 RGB panel: fetch a row from the frame
// buffer, shift it out on rgb/outclk, latch it, then display it for a fixed dwell.
module matrix_scan_ctrl #(
   parameter int COLS      = 32,
   parameter int ROW_PAIRS = 8,
   parameter int DWELL     = 64,
   localparam int RW  = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1,
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic [5:0]     pix_in,
   output logic [RW-1:0]  rd_row,
   output logic [CLW-1:0] rd_col,
   output logic [5:0]     rgb,
   output logic           outclk,
   output logic           lat,
   output logic           oe,
   output logic [RW-1:0]  abc,
   output logic           frame_done
);

   localparam int CMAX = (2 * COLS > DWELL - 1) ? 2 * COLS : DWELL - 1;
   localparam int CW   = $clog2(CMAX + 2);

   localparam logic [CW-1:0]  K_LAST   = CW'(2 * COLS);
   localparam logic [CW-1:0]  D_LAST   = CW'(DWELL - 1);
   localparam logic [CW-1:0]  COL_MAX  = CW'(COLS - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(ROW_PAIRS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

   state_t         state, state_n;
   logic [RW-1:0]  row, row_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [5:0]     rgb_n;
   logic           outclk_n, lat_n, oe_n, frame_done_n;
   logic [RW-1:0]  abc_n;
   logic [CLW-1:0] rd_col_n;
   logic [CW-1:0]  col_raw;
   logic [CLW-1:0] col_sat;

   // Address issued on an odd shift step, one ahead of the column captured next.
   always_comb begin
      col_raw = ((cnt + CW'(1)) >> 1) + CW'(1);
      col_sat = (col_raw > COL_MAX) ? CLW'(COLS - 1) : col_raw[CLW-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         row        <= '0;
         cnt        <= '0;
         rgb        <= '0;
         outclk     <= 1'b0;
         lat        <= 1'b0;
         oe         <= 1'b1;
         abc        <= '0;
         rd_row     <= '0;
         rd_col     <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         row        <= row_n;
         cnt        <= cnt_n;
         rgb        <= rgb_n;
         outclk     <= outclk_n;
         lat        <= lat_n;
         oe         <= oe_n;
         abc        <= abc_n;
         rd_row     <= row_n;
         rd_col     <= rd_col_n;
         frame_done <= frame_done_n;
      end
   end

   // Every output is computed one cycle ahead so the pins come straight from flops.
   always_comb begin
      state_n      = state;
      row_n        = row;
      cnt_n        = cnt;
      rgb_n        = rgb;
      outclk_n     = 1'b0;
      lat_n        = 1'b0;
      oe_n         = 1'b1;
      abc_n        = abc;
      rd_col_n     = rd_col;
      frame_done_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (en) begin
               state_n  = FETCH;
               rd_col_n = '0;
            end
         end
         FETCH: begin
            state_n  = SHIFT;
            cnt_n    = '0;
            rd_col_n = CLW'(1);
         end
         SHIFT: begin
            cnt_n = cnt + CW'(1);
            if (cnt == '0) begin
               rgb_n = pix_in;
            end else if (cnt[0]) begin
               outclk_n = 1'b1;
               rd_col_n = col_sat;
            end else if (cnt == K_LAST) begin
               rgb_n   = '0;
               state_n = LATCH;
               lat_n   = 1'b1;
               abc_n   = row;
            end else begin
               rgb_n = pix_in;
            end
         end
         LATCH: begin
            state_n = DISPLAY;
            cnt_n   = '0;
            oe_n    = 1'b0;
         end
         DISPLAY: begin
            if (cnt == D_LAST) begin
               row_n        = (row == ROW_LAST) ? '0 : row + RW'(1);
               frame_done_n = (row == ROW_LAST);
               state_n      = en ? FETCH : IDLE;
               if (en) rd_col_n = '0;
            end else begin
               cnt_n = cnt + CW'(1);
               oe_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomised bench for matrix_scan_ctrl: a position-in-row reference model checked
// every cycle, plus literal timing pins and a small-parameter instance.
module tb_matrix_scan_ctrl;

   localparam int C   = 32;
   localparam int R   = 8;
   localparam int D   = 64;
   localparam int PER = 2 * C + 3 + D;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [5:0] pix_in = '0;
   logic [2:0] rd_row, abc;
   logic [4:0] rd_col;
   logic [5:0] rgb;
   logic       outclk, lat, oe, frame_done;

   logic       en_s = 1'b1;
   logic [5:0] pix_s = '0;
   logic [0:0] rd_row_s, abc_s;
   logic [1:0] rd_col_s;
   logic [5:0] rgb_s;
   logic       outclk_s, lat_s, oe_s, fd_s;

   logic [5:0] fb [R][C];

   int total = 0;
   int bad = 0;
   int cyc = 0;

   bit m_active;
   int m_p, m_row, m_abc, m_lastcol;
   bit m_fd;

   int lat_cyc[$], lat_abc[$], lat_rises[$], fd_cyc[$], oe_low_run[$];
   int s_lats = 0;

   matrix_scan_ctrl dut (
      .clk(clk), .reset(reset), .en(en), .pix_in(pix_in),
      .rd_row(rd_row), .rd_col(rd_col), .rgb(rgb), .outclk(outclk),
      .lat(lat), .oe(oe), .abc(abc), .frame_done(frame_done)
   );

   matrix_scan_ctrl #(.COLS(4), .ROW_PAIRS(2), .DWELL(1)) dut_s (
      .clk(clk), .reset(reset), .en(en_s), .pix_in(pix_s),
      .rd_row(rd_row_s), .rd_col(rd_col_s), .rgb(rgb_s), .outclk(outclk_s),
      .lat(lat_s), .oe(oe_s), .abc(abc_s), .frame_done(fd_s)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Outputs implied by where the model sits inside the row period.
   function automatic logic [20:0] modelOutputs();
      int k, e_abc, e_col;
      logic [5:0] e_rgb;
      logic e_oc, e_lat, e_oe;
      e_rgb = '0; e_oc = 1'b0; e_lat = 1'b0; e_oe = 1'b1;
      e_abc = m_abc; e_col = m_lastcol;
      if (m_active) begin
         if (m_p == 0) begin
            e_col = 0;
         end else if (m_p <= 2 * C + 1) begin
            k = m_p - 1;
            e_col = (k / 2 + 1 < C - 1) ? k / 2 + 1 : C - 1;
            e_oc = (k >= 2 && k % 2 == 0);
            if (k >= 1) e_rgb = fb[m_row][(k - 1) / 2];
         end else begin
            e_col = C - 1;
            e_abc = m_row;
            if (m_p == 2 * C + 2) e_lat = 1'b1;
            else e_oe = 1'b0;
         end
      end
      return {e_rgb, e_oc, e_lat, e_oe, 3'(e_abc), 3'(m_row), 5'(e_col), m_fd};
   endfunction

   // Synchronous-read frame buffer: data for last cycle's address.
   initial begin
      logic [2:0] pr;
      logic [4:0] pc;
      pr = '0; pc = '0;
      forever begin
         @(negedge clk);
         pix_in = fb[pr][pc];
         pr = rd_row;
         pc = rd_col;
      end
   end

   // Reference model: row position advanced once per clock.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_active = 1'b0; m_p = 0; m_row = 0; m_abc = 0; m_lastcol = 0; m_fd = 1'b0; cyc = 0;
         end else begin
            cyc++;
            m_fd = 1'b0;
            if (!m_active) begin
               if (en) begin m_active = 1'b1; m_p = 0; end
            end else if (m_p == PER - 1) begin
               m_fd = (m_row == R - 1);
               m_abc = m_row;
               m_lastcol = C - 1;
               m_row = (m_row + 1) % R;
               m_active = en;
               m_p = 0;
            end else begin
               m_p++;
            end
         end
      end
   end

   // Per-cycle compare and protocol checks on the main instance.
   initial begin
      int rises, oe_run;
      bit prev_oc, prev_oe;
      logic [5:0] prev_rgb;
      rises = 0; oe_run = 0; prev_oc = 1'b0; prev_oe = 1'b1; prev_rgb = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rises = 0; oe_run = 0; prev_oc = 1'b0; prev_oe = 1'b1; prev_rgb = '0;
         end else begin
            checkOutput("cycle", 32'({rgb, outclk, lat, oe, abc, rd_row, rd_col, frame_done}),
                        32'(modelOutputs()));
            checkOutput("lat_while_oe_low", 32'(lat & ~oe), 0);
            checkOutput("outclk_while_oe_low", 32'(outclk & ~oe), 0);
            if (outclk && !prev_oc) begin
               checkOutput("rgb_hold_at_rise", 32'(rgb), 32'(prev_rgb));
               checkOutput("rise_col", 32'(rgb[2:0]), rises % 8);
               rises++;
            end
            if (lat) begin
               lat_cyc.push_back(cyc);
               lat_abc.push_back(int'(abc));
               lat_rises.push_back(rises);
               rises = 0;
            end
            if (!oe) oe_run++;
            else if (!prev_oe) begin oe_low_run.push_back(oe_run); oe_run = 0; end
            if (frame_done) fd_cyc.push_back(cyc);
            prev_oc = outclk; prev_oe = oe; prev_rgb = rgb;
         end
      end
   end

   // Small instance: 4 rises per row, 12-cycle rows, abc alternating.
   initial begin
      int rises_s, last_s, exp_abc_s;
      bit prev_oc_s;
      rises_s = 0; last_s = -1; exp_abc_s = 0; prev_oc_s = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rises_s = 0; last_s = -1; exp_abc_s = 0; prev_oc_s = 1'b0;
         end else begin
            if (outclk_s && !prev_oc_s) rises_s++;
            if (lat_s) begin
               s_lats++;
               checkOutput("s_rises", rises_s, 4);
               checkOutput("s_abc", 32'(abc_s), exp_abc_s);
               if (last_s >= 0) checkOutput("s_period", cyc - last_s, 12);
               last_s = cyc;
               exp_abc_s = 1 - exp_abc_s;
               rises_s = 0;
            end
            prev_oc_s = outclk_s;
         end
      end
   end

   task automatic waitRowPos(input int row, input int pos, input int limit, input string name);
      int n = 0;
      while (!(m_active && m_row == row && m_p == pos) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(n < limit), 1);
   endtask

   task automatic waitLatCount(input int cnt, input int limit, input string name);
      int n = 0;
      while (lat_cyc.size() < cnt && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(n < limit), 1);
   endtask

   task automatic applyStimulus();
      int n0, n, t0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            fb[r][c] = {3'($urandom_range(0, 7)), 3'(c % 8)};

      en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3150) @(negedge clk);

      checkOutput("first_frame_lat_count", 32'(lat_cyc.size() >= 9), 1);
      if (lat_cyc.size() >= 9) begin
         checkOutput("first_lat_cycle", lat_cyc[0], 67);
         checkOutput("row_period", lat_cyc[1] - lat_cyc[0], 131);
         checkOutput("rises_row0", lat_rises[0], 32);
         for (int i = 0; i < 9; i++) checkOutput("abc_sequence", lat_abc[i], i % 8);
      end
      checkOutput("dwell_seen", 32'(oe_low_run.size() >= 1), 1);
      if (oe_low_run.size() >= 1) checkOutput("dwell_row0", oe_low_run[0], 64);
      checkOutput("frame_done_count", fd_cyc.size(), 3);
      if (fd_cyc.size() >= 2) begin
         checkOutput("frame_done_first", fd_cyc[0], 1049);
         checkOutput("frame_done_second", fd_cyc[1], 2097);
      end

      waitRowPos(3, 10, 3000, "reach_row3_shift");
      en = 1'b0;
      n0 = lat_cyc.size();
      n = 0;
      while (m_active && n < 400) begin @(negedge clk); n++; end
      checkOutput("row3_completes", 32'(n < 400), 1);
      repeat (20) @(negedge clk);
      checkOutput("row3_one_latch", lat_cyc.size() - n0, 1);
      if (lat_cyc.size() > n0) begin
         checkOutput("row3_abc", lat_abc[n0], 3);
         checkOutput("row3_dwell", oe_low_run[oe_low_run.size() - 1], 64);
      end
      t0 = cyc;
      en = 1'b1;
      waitLatCount(n0 + 2, 300, "resume_latch");
      if (lat_cyc.size() >= n0 + 2) begin
         checkOutput("resume_abc", lat_abc[n0 + 1], 4);
         checkOutput("resume_lat_time", lat_cyc[n0 + 1] - t0, 67);
      end

      repeat (3000) begin
         @(negedge clk);
         en = ($urandom_range(0, 3) != 0);
      end

      en = 1'b1;
      waitRowPos(5, 2 * C + 3 + 20, 3000, "reach_row5_display");
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_oe", 32'(oe), 1);
      checkOutput("rst_abc", 32'(abc), 0);
      checkOutput("rst_lat", 32'(lat), 0);
      checkOutput("rst_rgb", 32'(rgb), 0);
      checkOutput("rst_outclk", 32'(outclk), 0);
      repeat (2) @(negedge clk);
      n0 = lat_cyc.size();
      reset = 1'b0;
      waitLatCount(n0 + 1, 200, "restart_latch");
      if (lat_cyc.size() > n0) begin
         checkOutput("restart_abc", lat_abc[n0], 0);
         checkOutput("restart_lat_time", lat_cyc[n0], 67);
      end
      repeat (200) @(negedge clk);
      checkOutput("s_lat_count", 32'(s_lats >= 100), 1);
   endtask

   initial begin
      applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
